// File: rtl/reset_sequencer_if.sv
// Reset-sequencer output bundle: per-channel resets, sequence status, and the
// software reset request (request exists only when RESET_SEQ_SWREQ_EN is defined).
interface reset_sequencer_if #(
    parameter int NCHAN = 4
);
    logic [NCHAN-1:0] OUT_RST;
    logic             SEQ_BUSY;
    logic             SEQ_DONE;
`ifdef RESET_SEQ_SWREQ_EN
    logic             SW_RST_REQ;

    modport master (
        output OUT_RST,
        output SEQ_BUSY,
        output SEQ_DONE,
        input  SW_RST_REQ
    );

    modport slave (
        input  OUT_RST,
        input  SEQ_BUSY,
        input  SEQ_DONE,
        output SW_RST_REQ
    );
`else
    modport master (
        output OUT_RST,
        output SEQ_BUSY,
        output SEQ_DONE
    );

    modport slave (
        input  OUT_RST,
        input  SEQ_BUSY,
        input  SEQ_DONE
    );
`endif
endinterface

// File: rtl/reset_sequencer.sv
// Staggered multi-channel reset release: channel k drops at E(RSTDELAY+1+k*STAGE_GAP).
// All outputs registered; IN_RST re-asserts every channel at the sampling edge.
// No backpressure; optional SW reset request under RESET_SEQ_SWREQ_EN.
module reset_sequencer #(
    parameter int NCHAN     = 4,
    parameter int RSTDELAY  = 1,
    parameter int STAGE_GAP = 2,
    parameter int SW_HOLD   = 4
) (
    input  logic              CLK,
    input  logic              IN_RST,
    reset_sequencer_if.master seq
);

    localparam int LAST = RSTDELAY + (NCHAN - 1) * STAGE_GAP;
    localparam int CMAX = (LAST > SW_HOLD) ? LAST : SW_HOLD;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] LAST_C = CW'(LAST);

`ifdef RESET_SEQ_SWREQ_EN
    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_SWHOLD = 2'd1,
        ST_COUNT  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NCHAN-1:0] out_rst_q, out_rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CW-1:0]    rel_idx;
    logic [NCHAN-1:0] rel_mask;
    logic             advance;

    // rel_idx is the release-edge index being taken this cycle: 0 at E1, 1 at E2, ...
    always_comb begin
        rel_idx = '0;
        if (state_q == ST_COUNT) begin
            rel_idx = cnt_q + CW'(1);
        end
    end

    always_comb begin
        rel_mask = '0;
        for (int k = 0; k < NCHAN; k++) begin
            if (rel_idx == CW'(RSTDELAY + k * STAGE_GAP)) begin
                rel_mask[k] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_rst_d = out_rst_q;
        busy_d    = busy_q;
        done_d    = done_q;
        advance   = 1'b0;

        case (state_q)
            ST_HOLD:  advance = 1'b1;
`ifdef RESET_SEQ_SWREQ_EN
            ST_SWHOLD: begin
                if (cnt_q == CW'(SW_HOLD - 1)) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            ST_COUNT: advance = 1'b1;
            ST_DONE: begin
`ifdef RESET_SEQ_SWREQ_EN
                if (seq.SW_RST_REQ) begin
                    state_d   = ST_SWHOLD;
                    cnt_d     = '0;
                    out_rst_d = '1;
                    done_d    = 1'b0;
                end
`endif
            end
            default:  state_d = ST_HOLD;
        endcase

        // The edge leaving HOLD/SWHOLD is E1 and may already release channels.
        if (advance) begin
            cnt_d     = rel_idx;
            out_rst_d = out_rst_q & ~rel_mask;
            if (rel_idx == LAST_C) begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d = ST_COUNT;
                busy_d  = 1'b1;
                done_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (IN_RST) begin
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            out_rst_q <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_rst_q <= out_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign seq.OUT_RST  = out_rst_q;
    assign seq.SEQ_BUSY = busy_q;
    assign seq.SEQ_DONE = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: staggered (3,1,2) and simultaneous (4,0,0) instances,
// directed plan steps, then random IN_RST / SW_RST_REQ against a lows-count model.
module tb_reset_sequencer;

    localparam int A_N = 3, A_RD = 1, A_GAP = 2, A_SWH = 4;
    localparam int B_N = 4, B_RD = 0, B_GAP = 0, B_SWH = 1;
    localparam int A_LAST = A_RD + (A_N - 1) * A_GAP;
    localparam int B_LAST = B_RD + (B_N - 1) * B_GAP;
`ifdef RESET_SEQ_SWREQ_EN
    localparam bit SWEN = 1'b1;
`else
    localparam bit SWEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   nchecks = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    reset_sequencer_if #(.NCHAN(A_N)) if_a ();
    reset_sequencer_if #(.NCHAN(B_N)) if_b ();

    reset_sequencer #(.NCHAN(A_N), .RSTDELAY(A_RD), .STAGE_GAP(A_GAP), .SW_HOLD(A_SWH)) dut_a (
        .CLK(clk), .IN_RST(rst_a), .seq(if_a.master));
    reset_sequencer #(.NCHAN(B_N), .RSTDELAY(B_RD), .STAGE_GAP(B_GAP), .SW_HOLD(B_SWH)) dut_b (
        .CLK(clk), .IN_RST(rst_b), .seq(if_b.master));

    // lows = number of edges since the sequence's E1 inclusive (0 = held in reset)
    typedef struct {
        int lows;
        int swrem;
        bit seen;
    } mdl_t;

    mdl_t ma = '{0, 0, 1'b0};
    mdl_t mb = '{0, 0, 1'b0};

    function automatic mdl_t mstep(mdl_t m, bit rst, bit sw, int last, int swhold);
        mdl_t n = m;
        if (rst) begin
            n.lows = 0; n.swrem = 0; n.seen = 1'b1;
        end else if (n.swrem > 0) begin
            n.swrem--;
            if (n.swrem == 0) n.lows = 1;
        end else if (SWEN && sw && n.lows > last) begin
            n.lows = 0; n.swrem = swhold;
        end else if (n.lows <= last) begin
            n.lows++;
        end
        return n;
    endfunction

    function automatic logic [31:0] eout(int lows, int nchan, int rd, int gap);
        logic [31:0] v = '0;
        for (int k = 0; k < nchan; k++) v[k] = (lows < rd + 1 + k * gap);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_models();
        if (ma.seen) begin
            chk("a_out",  32'(if_a.OUT_RST),  eout(ma.lows, A_N, A_RD, A_GAP));
            chk("a_busy", 32'(if_a.SEQ_BUSY), 32'(ma.lows >= 1 && ma.lows <= A_LAST));
            chk("a_done", 32'(if_a.SEQ_DONE), 32'(ma.lows > A_LAST));
        end
        if (mb.seen) begin
            chk("b_out",  32'(if_b.OUT_RST),  eout(mb.lows, B_N, B_RD, B_GAP));
            chk("b_busy", 32'(if_b.SEQ_BUSY), 32'(mb.lows >= 1 && mb.lows <= B_LAST));
            chk("b_done", 32'(if_b.SEQ_DONE), 32'(mb.lows > B_LAST));
        end
    endtask

    // Drive inputs, take one rising edge, advance the model, compare on the falling edge.
    task automatic cyc(input bit ra, input bit rb, input bit sw);
        rst_a = ra;
        rst_b = rb;
`ifdef RESET_SEQ_SWREQ_EN
        if_a.SW_RST_REQ = sw;
        if_b.SW_RST_REQ = sw;
`endif
        @(posedge clk);
        ma = mstep(ma, ra, sw, A_LAST, A_SWH);
        mb = mstep(mb, rb, sw, B_LAST, B_SWH);
        @(negedge clk);
        check_models();
    endtask

    initial begin
`ifdef RESET_SEQ_SWREQ_EN
        if_a.SW_RST_REQ = 1'b0;
        if_b.SW_RST_REQ = 1'b0;
`endif
        // Reset for three cycles
        cyc(1, 1, 0);
        chk("rst_a_out", 32'(if_a.OUT_RST), 32'h7);
        chk("rst_a_busy", 32'(if_a.SEQ_BUSY), 32'h0);
        chk("rst_a_done", 32'(if_a.SEQ_DONE), 32'h0);
        chk("rst_b_out", 32'(if_b.OUT_RST), 32'hf);
        cyc(1, 1, 0);
        cyc(1, 1, 0);

        // Release order
        cyc(0, 0, 0);  // E1
        chk("e1_a_out", 32'(if_a.OUT_RST), 32'h7);
        chk("e1_a_busy", 32'(if_a.SEQ_BUSY), 32'h1);
        chk("e1_b_out", 32'(if_b.OUT_RST), 32'h0);
        chk("e1_b_busy", 32'(if_b.SEQ_BUSY), 32'h0);
        chk("e1_b_done", 32'(if_b.SEQ_DONE), 32'h1);
        cyc(0, 0, 0);  // E2
        chk("e2_a_out", 32'(if_a.OUT_RST), 32'h6);
        cyc(0, 0, 0);  // E3
        cyc(0, 0, 0);  // E4
        chk("e4_a_out", 32'(if_a.OUT_RST), 32'h4);
        cyc(0, 0, 0);  // E5
        chk("e5_a_busy", 32'(if_a.SEQ_BUSY), 32'h1);
        chk("e5_a_done", 32'(if_a.SEQ_DONE), 32'h0);
        cyc(0, 0, 0);  // E6
        chk("e6_a_out", 32'(if_a.OUT_RST), 32'h0);
        chk("e6_a_busy", 32'(if_a.SEQ_BUSY), 32'h0);
        chk("e6_a_done", 32'(if_a.SEQ_DONE), 32'h1);

        // Reset pulse mid-sequence
        cyc(1, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        chk("mid_pre_a_out", 32'(if_a.OUT_RST), 32'h6);
        cyc(1, 0, 0);
        chk("mid_a_out", 32'(if_a.OUT_RST), 32'h7);
        chk("mid_a_busy", 32'(if_a.SEQ_BUSY), 32'h0);
        cyc(0, 0, 0);
        chk("mid_e1_a_out", 32'(if_a.OUT_RST), 32'h7);
        cyc(0, 0, 0);
        chk("mid_e2_a_out", 32'(if_a.OUT_RST), 32'h6);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0);

        // Stability in DONE
        for (int i = 0; i < 1000; i++) cyc(0, 0, 0);
        chk("idle_a_out", 32'(if_a.OUT_RST), 32'h0);
        chk("idle_a_done", 32'(if_a.SEQ_DONE), 32'h1);

`ifdef RESET_SEQ_SWREQ_EN
        // Software request, then an ignored request during COUNT
        cyc(0, 0, 1);
        chk("sw_a_out", 32'(if_a.OUT_RST), 32'h7);
        chk("sw_a_done", 32'(if_a.SEQ_DONE), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            chk("swhold_a_out", 32'(if_a.OUT_RST), 32'h7);
            chk("swhold_a_busy", 32'(if_a.SEQ_BUSY), 32'h0);
        end
        cyc(0, 0, 0);  // E1
        chk("sw_e1_a_busy", 32'(if_a.SEQ_BUSY), 32'h1);
        cyc(0, 0, 0);  // E2
        chk("sw_e2_a_out", 32'(if_a.OUT_RST), 32'h6);
        cyc(0, 0, 1);  // E3, ignored request
        chk("sw_ign_a_out", 32'(if_a.OUT_RST), 32'h6);
        cyc(0, 0, 0);  // E4
        chk("sw_e4_a_out", 32'(if_a.OUT_RST), 32'h4);
        cyc(0, 0, 0);
        cyc(0, 0, 0);  // E6
        chk("sw_e6_a_out", 32'(if_a.OUT_RST), 32'h0);
        chk("sw_e6_a_done", 32'(if_a.SEQ_DONE), 32'h1);
`endif

        // Random resets and requests against the model
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
                SWEN && ($urandom_range(0, 4) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
